nibble_addsub_seq: RTL and testbench
====================================

Name: nibble_addsub_seq

Overview:
Multi-cycle controller that runs a WIDTH-bit add or subtract through one shared 4-bit ripple add/sub slice, one nibble per clock, LSB first. The carry is held in a register between nibbles. Subtract uses the slice's usual scheme: B is XORed with the op bit, and the op bit is the initial carry-in. The block sits between a simple start/done requester (FSM, test driver) and the 4-bit slice datapath, and holds the final result and flags until the next operation.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation; WIDTH = 4*NIBBLES (default 16); must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
sub  input  1  0 = A+B, 1 = A-B; captured with start
a  input  WIDTH  operand A; captured with start
b  input  WIDTH  operand B; captured with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when result/flags update
result  output  WIDTH  sum/difference, registered, held until next done
c_out  output  1  carry out of MSB (subtract: 1 = no borrow, i.e. A >= B unsigned)
ovf  output  1  signed overflow = carry-into-MSB XOR carry-out-of-MSB
zero  output  1  result == 0

Behaviour:
- Reset (async, any time, including mid-operation):
  - state = IDLE; busy, done, result, c_out, ovf and zero all 0; index and carry register cleared.
  - An aborted operation never produces done.
- States: IDLE, RUN. A nibble index idx counts 0..NIBBLES-1.
- IDLE:
  - On an edge with start=1 (edge E0): latch a, b and sub; carry_reg <= sub; idx <= 0; go to RUN; busy=1 from E0.
  - start=0: remain in IDLE.
- RUN, each edge Ek (k = 1..NIBBLES) processes nibble k-1:
  - bx = b_nib XOR {4{sub}}.
  - {cy, s} = a_nib + bx + carry_reg, ripple per bit.
  - Store s into nibble k-1 of an internal accumulator; carry_reg <= cy; idx++.
- Last nibble (edge E_NIBBLES):
  - result <= full accumulator, with the last nibble included.
  - c_out <= carry out of bit WIDTH-1.
  - ovf <= carry into bit WIDTH-1 XOR c_out.
  - zero <= (new result == 0).
  - done <= 1 for exactly one cycle; busy <= 0; state back to IDLE.
- Latency: done and the new result become visible NIBBLES cycles after the capture edge E0. With NIBBLES=4, start sampled at edge 0 gives done high between edges 4 and 5.
- start while busy=1 is ignored; nothing is queued.
- Back-to-back: start may be high in the done cycle. It is accepted at the next edge, giving one operation every NIBBLES+1 cycles.
- Operand inputs changing during RUN have no effect; only the latched copies are used.
- result, c_out, ovf and zero change only at a done edge or at reset. done is 0 in all other cycles.
- Arithmetic is modulo 2^WIDTH. NIBBLES=1 is legal: RUN lasts one edge.

Test Plan:
- Reset then idle: rst pulse, start=0 for 10 cycles -> busy=0, done=0, result=0x0000, all flags 0.
- Add: a=0x1234, b=0x0FFF, sub=0 -> done exactly 4 cycles after capture; result=0x2233, c_out=0, ovf=0, zero=0. Also a=0xFFFF, b=0x0001 -> 0x0000, c_out=1, zero=1, ovf=0.
- Subtract: a=0x0005, b=0x0007, sub=1 -> 0xFFFE, c_out=0, ovf=0. Also a=0x8000, b=0x0001, sub=1 -> 0x7FFF, c_out=1, ovf=1.
- Signed overflow on add: a=0x7FFF, b=0x0001 -> 0x8000, ovf=1, c_out=0.
- Protocol:
  - Hold start=1 continuously with changing operands -> done every 5 cycles; each result matches the operands present at its capture edge.
  - Pulse start and change a/b while busy -> no effect; result matches the captured values.
- Reset mid-operation: assert rst 2 cycles into a 0x1234+0x0FFF run -> outputs 0 immediately (asynchronous) and no done. After release, a new start=1 with a=0x0001, b=0x0001 -> 0x0002 after 4 cycles.

Source files
------------

// File: rtl/nibble_addsub_seq.sv
// nibble_addsub_seq
// Runs a WIDTH-bit add or subtract through a single 4-bit ripple add/sub
// slice, one nibble per clock, least significant nibble first. The carry
// between nibbles is held in a register. Subtract is done as A + ~B + 1:
// each B nibble is inverted with the op bit, and the op bit is the first
// carry-in.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - request, sampled only while busy is low
//   sub    - 0 = A+B, 1 = A-B (captured with start)
//   a, b   - WIDTH-bit operands (captured with start)
//   busy   - high while an operation is in progress
//   done   - one-cycle pulse when result and flags update
//   result - sum/difference, held until the next done
//   c_out  - carry out of the MSB (subtract: 1 = no borrow)
//   ovf    - signed overflow (carry into MSB XOR carry out of MSB)
//   zero   - result equals zero
module nibble_addsub_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 c_out,
    output logic                 ovf,
    output logic                 zero
);

    localparam int WIDTH = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One 4-bit ripple add/sub slice.
    // Returns {carry into bit 3, carry out of bit 3, sum[3:0]}; the carry
    // into bit 3 of the last nibble is the carry into the word MSB, which
    // is what the signed overflow flag needs.
    function automatic logic [5:0] nibble_slice(
        input logic [3:0] a_nib,
        input logic [3:0] b_nib,
        input logic       sub_i,
        input logic       cin
    );
        logic [3:0] bx;
        logic [3:0] s;
        logic [4:0] c;
        bx   = b_nib ^ {4{sub_i}};
        c    = 5'b00000;
        s    = 4'b0000;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a_nib[i] ^ bx[i] ^ c[i];
            c[i + 1] = (a_nib[i] & bx[i]) | (c[i] & (a_nib[i] ^ bx[i]));
        end
        return {c[3], c[4], s};
    endfunction

    state_t           state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             carry_q,  carry_d;
    logic             sub_q,    sub_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_out_q,  c_out_d;
    logic             ovf_q,    ovf_d;
    logic             zero_q,   zero_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic [IDX_W+1:0] nib_off_s;
    logic [5:0]       slice_s;

    // Bit offset of the nibble being processed and the slice working on it.
    assign nib_off_s = {idx_q, 2'b00};
    assign slice_s   = nibble_slice(a_q[nib_off_s +: 4], b_q[nib_off_s +: 4], sub_q, carry_q);

    // Next-state and next-output computation for the controller.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        sub_d    = sub_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Latch operands so later input changes cannot disturb the run.
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    carry_d = sub;
                    idx_d   = {IDX_W{1'b0}};
                    acc_d   = {WIDTH{1'b0}};
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                acc_d[nib_off_s +: 4] = slice_s[3:0];
                carry_d               = slice_s[4];
                if (idx_q == LAST_IDX) begin
                    // acc_d already holds the final nibble here.
                    result_d = acc_d;
                    c_out_d  = slice_s[4];
                    ovf_d    = slice_s[5] ^ slice_s[4];
                    zero_d   = (acc_d == {WIDTH{1'b0}});
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    idx_d    = {IDX_W{1'b0}};
                    state_d  = ST_IDLE;
                end else begin
                    idx_d    = idx_q + IDX_W'(1'b1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                idx_d   = {IDX_W{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= {IDX_W{1'b0}};
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            sub_q    <= sub_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign c_out  = c_out_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_nibble_addsub_seq.sv
// Testbench for nibble_addsub_seq (NIBBLES = 4, WIDTH = 16).
// Directed operations push their hand-computed results into a scoreboard
// queue; a monitor on the falling edge pops and compares on every done,
// checks the done latency, and checks that result/flags hold otherwise.
module tb_nibble_addsub_seq;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic [W-1:0] a     = 16'h0000;
    logic [W-1:0] b     = 16'h0000;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic         ovf;
    logic         zero;

    nibble_addsub_seq #(.NIBBLES(NIB)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .c_out  (c_out),
        .ovf    (ovf),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         o;
        logic         z;
        int           cap;
    } exp_t;

    exp_t  sb[$];
    int    checks   = 0;
    int    failures = 0;
    logic [W+2:0] held = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: compares outputs on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = '0;
                check("in_reset", {busy, done, result, c_out, ovf, zero}, 32'h0);
            end else if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", {31'h0, done}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("done_latency", cyc, e.cap + NIB);
                    check("result", result, e.res);
                    check("flags_c_o_z", {c_out, ovf, zero}, {e.c, e.o, e.z});
                    check("busy_in_done", busy, 1'b0);
                    held = {e.res, e.c, e.o, e.z};
                end
            end else begin
                check("hold_outputs", {result, c_out, ovf, zero}, held);
            end
        end
    end

    // Issue one operation; mode 0: start low while busy, 1: start held high,
    // 2: one extra start pulse while busy. Operands are scrambled while busy.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                          input logic [W-1:0] res, input logic c, input logic o,
                          input logic z, input int mode);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        sub   = sv;
        e.res = res;
        e.c   = c;
        e.o   = o;
        e.z   = z;
        e.cap = cyc + 1;
        sb.push_back(e);
        for (int i = 0; i < NIB; i++) begin
            @(negedge clk);
            if (i == 0) check("busy_after_capture", busy, 1'b1);
            a     = av ^ 16'hFFFF;
            b     = bv ^ 16'h0F0F;
            sub   = ~sv;
            start = (mode == 1) || ((mode == 2) && (i == 1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;
        #2 check("reset_outputs", {busy, done, result, c_out, ovf, zero}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(10);
        check("idle_busy_done", {busy, done}, 32'h0);

        // Single operations, back to back in the done cycle.
        run_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
        idle(2);

        // start held high continuously with changing operands.
        run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1);
        run_op(16'h1000, 16'h1000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1);
        run_op(16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1'b0, 1);
        run_op(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1);
        idle(2);

        // Extra start pulse while busy must be ignored.
        run_op(16'h4321, 16'h0321, 1'b1, 16'h4000, 1'b1, 1'b0, 1'b0, 2);
        idle(3);

        // Reset in the middle of an operation: no done may follow.
        @(negedge clk);
        start = 1'b1;
        a     = 16'h1234;
        b     = 16'h0FFF;
        sub   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("midop_reset_outputs", {busy, done, result, c_out, ovf, zero}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(6);
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 0);
        idle(3);

        check("scoreboard_empty", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
